csa_sbox_layer: RTL and testbench

Registered S-box layer of the CSA stream cipher, sitting between the A-register state update and the X/Y/Z combiner. Each accepted 40-bit A snapshot is routed through the seven 5-in/2-out S-boxes (`sbox1`..`sbox7`) and packed into three nibbles (X, Y, Z). Results are buffered in a 2-entry output queue under a valid/ready handshake, so the state-update stage can stall independently of the combiner.

---
 rtl/csa_pkg.sv | 59 +++++
 rtl/csa_sbox_bank.sv | 60 ++++++
 rtl/csa_sbox_layer.sv | 113 +++++++++++
 tb/tb_csa_sbox_layer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared types and constants for the CSA S-box layer (taps, lookup tables, packing order).
// Latency: n/a (declarations and one combinational gather helper).
// Backpressure: n/a.
package csa_pkg;

    // One combiner result: three nibbles fed to the X/Y/Z combiner.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } csa_xyz_t;

    localparam int CSA_NBOX    = 7;
    localparam int CSA_SK_BITS = 5 * CSA_NBOX;

    // Bit positions in a_state feeding each S-box; element [k][4] is the S-box input MSB.
    // Bit position = 4*(nibble-1) + bit-within-nibble.
    localparam logic [5:0] CSA_SBOX_TAP [1:7][4:0] = '{
        '{6'd12, 6'd2,  6'd21, 6'd27, 6'd32},   // sbox1: A4.0 A1.2 A6.1 A7.3 A9.0
        '{6'd5,  6'd10, 6'd23, 6'd24, 6'd33},   // sbox2: A2.1 A3.2 A6.3 A7.0 A9.1
        '{6'd3,  6'd4,  6'd17, 6'd19, 6'd22},   // sbox3: A1.3 A2.0 A5.1 A5.3 A6.2
        '{6'd11, 6'd1,  6'd7,  6'd14, 6'd28},   // sbox4: A3.3 A1.1 A2.3 A4.2 A8.0
        '{6'd18, 6'd15, 6'd20, 6'd29, 6'd34},   // sbox5: A5.2 A4.3 A6.0 A8.1 A9.2
        '{6'd9,  6'd13, 6'd16, 6'd26, 6'd35},   // sbox6: A3.1 A4.1 A5.0 A7.2 A9.3
        '{6'd6,  6'd8,  6'd25, 6'd30, 6'd31}    // sbox7: A2.2 A3.0 A7.1 A8.2 A8.3
    };

    // S-box contents, 32 two-bit outputs each, indexed by the 5-bit input.
    localparam int CSA_SBOX_LUT [1:7][0:31] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    // Packing order: nibble bit [i] takes bit CSA_*_BIT[i] of S-box CSA_*_BOX[i].
    localparam int CSA_X_BOX [3:0] = '{4, 3, 2, 1};
    localparam int CSA_X_BIT [3:0] = '{0, 0, 1, 1};
    localparam int CSA_Y_BOX [3:0] = '{6, 5, 4, 3};
    localparam int CSA_Y_BIT [3:0] = '{0, 0, 1, 1};
    localparam int CSA_Z_BOX [3:0] = '{2, 1, 7, 6};
    localparam int CSA_Z_BIT [3:0] = '{0, 0, 1, 1};

    // Gather the 35 S-box input bits; S-box k occupies bits [5k-1:5k-5].
    function automatic logic [CSA_SK_BITS-1:0] csa_gather(input logic [39:0] a);
        logic [CSA_SK_BITS-1:0] g;
        g = '0;
        for (int k = 1; k <= CSA_NBOX; k++) begin
            for (int b = 0; b < 5; b++) begin
                g[5*(k-1)+b] = a[CSA_SBOX_TAP[k][b]];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/csa_sbox_bank.sv
// csa_sbox_bank: the seven CSA 5-in/2-out S-boxes plus the fixed X/Y/Z nibble packing.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all handshaking.

module sbox1 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[1][sin]);
endmodule

module sbox2 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[2][sin]);
endmodule

module sbox3 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[3][sin]);
endmodule

module sbox4 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[4][sin]);
endmodule

module sbox5 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[5][sin]);
endmodule

module sbox6 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[6][sin]);
endmodule

module sbox7 import csa_pkg::*; (input logic [4:0] sin, output logic [1:0] sout);
    assign sout = 2'(CSA_SBOX_LUT[7][sin]);
endmodule

module csa_sbox_bank
    import csa_pkg::*;
(
    input  logic [CSA_SK_BITS-1:0] sk_in,
    output csa_xyz_t               xyz
);

    logic [7:1][1:0] s;

    sbox1 u_sbox1 (.sin(sk_in[4:0]),   .sout(s[1]));
    sbox2 u_sbox2 (.sin(sk_in[9:5]),   .sout(s[2]));
    sbox3 u_sbox3 (.sin(sk_in[14:10]), .sout(s[3]));
    sbox4 u_sbox4 (.sin(sk_in[19:15]), .sout(s[4]));
    sbox5 u_sbox5 (.sin(sk_in[24:20]), .sout(s[5]));
    sbox6 u_sbox6 (.sin(sk_in[29:25]), .sout(s[6]));
    sbox7 u_sbox7 (.sin(sk_in[34:30]), .sout(s[7]));

    // Route S-box output bits into the three nibbles using the package packing tables.
    always_comb begin
        xyz = '0;
        for (int i = 0; i < 4; i++) begin
            xyz.x[i] = s[CSA_X_BOX[i]][CSA_X_BIT[i]];
            xyz.y[i] = s[CSA_Y_BOX[i]][CSA_Y_BIT[i]];
            xyz.z[i] = s[CSA_Z_BOX[i]][CSA_Z_BIT[i]];
        end
    end

endmodule

// File: rtl/csa_sbox_layer.sv
// csa_sbox_layer: CSA S-box layer, A snapshot -> {X,Y,Z} nibbles via a 2-entry output queue.
// Latency: accept-to-out_valid 1 cycle; 2 cycles when CSA_SBOX_PIPE_EN is defined (gather register).
// Backpressure: in_ready = occupancy < 2 from registered state only; no out_ready->in_ready path.
module csa_sbox_layer
    import csa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] a_state,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  x_nib,
    output logic [3:0]  y_nib,
    output logic [3:0]  z_nib,
    output logic [1:0]  occupancy
);

    if (DEPTH != 2) begin : g_depth_chk
        $error("csa_sbox_layer: DEPTH must be 2");
    end

    localparam logic [1:0] OCC_CAP = 2'd2;

    logic                   acc_vld;
    logic                   pop_vld;
    logic                   q_push;
    logic [1:0]             q_cnt;
    csa_xyz_t               q_dat [2];
    csa_xyz_t               bank_xyz;
    csa_xyz_t               head_dat;
    logic [CSA_SK_BITS-1:0] sk_gather;
    logic [CSA_SK_BITS-1:0] bank_sk;

    assign acc_vld   = in_valid && in_ready;
    assign pop_vld   = out_valid && out_ready;
    assign sk_gather = csa_gather(a_state);

`ifdef CSA_SBOX_PIPE_EN
    logic                   stg_vld;
    logic [CSA_SK_BITS-1:0] stg_sk;

    // Gather register: holds the 35 tapped bits of an accepted snapshot for one cycle.
    // It always drains into the queue next cycle: the occupancy cap guarantees a free slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= 1'b0;
            stg_sk  <= '0;
        end else begin
            stg_vld <= acc_vld;
            if (acc_vld) begin
                stg_sk <= sk_gather;
            end
        end
    end

    assign bank_sk   = stg_sk;
    assign q_push    = stg_vld;
    assign occupancy = q_cnt + {1'b0, stg_vld};
`else
    assign bank_sk   = sk_gather;
    assign q_push    = acc_vld;
    assign occupancy = q_cnt;
`endif

    csa_sbox_bank u_bank (
        .sk_in (bank_sk),
        .xyz   (bank_xyz)
    );

    // Output queue, entry 0 is the head; a pop shifts entry 1 forward.
    // Push while full cannot happen: in_ready is low whenever occupancy has reached the cap.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt    <= 2'd0;
            q_dat[0] <= '0;
            q_dat[1] <= '0;
        end else begin
            case ({q_push, pop_vld})
                2'b10: begin
                    q_dat[q_cnt[0]] <= bank_xyz;
                    q_cnt           <= q_cnt + 2'd1;
                end
                2'b01: begin
                    q_dat[0] <= q_dat[1];
                    q_cnt    <= q_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new result lands behind whatever remains.
                    if (q_cnt == 2'd1) begin
                        q_dat[0] <= bank_xyz;
                    end else begin
                        q_dat[0] <= q_dat[1];
                        q_dat[1] <= bank_xyz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (occupancy < OCC_CAP);
    assign out_valid = (q_cnt != 2'd0);
    assign head_dat  = out_valid ? q_dat[0] : '0;
    assign x_nib     = head_dat.x;
    assign y_nib     = head_dat.y;
    assign z_nib     = head_dat.z;

endmodule

// File: tb/tb_csa_sbox_layer.sv
// tb_csa_sbox_layer: randomized and directed checks of csa_sbox_layer against a behavioural model.
// Latency: n/a.
// Backpressure: drives out_ready patterns including long stalls.
module tb_csa_sbox_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] a_state;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  x_nib;
    logic [3:0]  y_nib;
    logic [3:0]  z_nib;
    logic [1:0]  occupancy;

    always #5 clk = ~clk;

    csa_sbox_layer #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_state   (a_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_nib     (x_nib),
        .y_nib     (y_nib),
        .z_nib     (z_nib),
        .occupancy (occupancy)
    );

    // Reference S-box tables.
    localparam int SB [1:7][0:31] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };
    // Taps as (A nibble number, bit within nibble), listed from S-box input MSB to LSB.
    localparam int TN [1:7][0:4] = '{
        '{4,1,6,7,9}, '{2,3,6,7,9}, '{1,2,5,5,6}, '{3,1,2,4,8},
        '{5,4,6,8,9}, '{3,4,5,7,9}, '{2,3,7,8,8}
    };
    localparam int TB [1:7][0:4] = '{
        '{0,2,1,3,0}, '{1,2,3,0,1}, '{3,0,1,3,2}, '{3,1,3,2,0},
        '{2,3,0,1,2}, '{1,1,0,2,3}, '{2,0,1,2,3}
    };

    int          checks   = 0;
    int          failures = 0;
    int          nacc     = 0;
    int          npop     = 0;
    logic [11:0] mq [$];

    // Expected {x,y,z} for one A snapshot.
    function automatic logic [11:0] model(input logic [39:0] a);
        logic [1:0] s [1:7];
        logic [3:0] x, y, z;
        int         idx;
        for (int k = 1; k <= 7; k++) begin
            idx = 0;
            for (int j = 0; j < 5; j++) begin
                idx = idx * 2 + (a[4 * (TN[k][j] - 1) + TB[k][j]] ? 1 : 0);
            end
            s[k] = 2'(SB[k][idx]);
        end
        x = {s[4][0], s[3][0], s[2][1], s[1][1]};
        y = {s[6][0], s[5][0], s[4][1], s[3][1]};
        z = {s[2][0], s[1][0], s[7][1], s[6][1]};
        return {x, y, z};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then model update from this cycle's handshakes.
    task automatic check_cycle();
        logic acc, pop;
        if (rst) begin
            mq.delete();
            return;
        end
        chk("occupancy", 16'(occupancy), 16'(mq.size()));
        chk("in_ready", 16'(in_ready), 16'(mq.size() < 2));
`ifndef CSA_SBOX_PIPE_EN
        chk("out_valid", 16'(out_valid), 16'(mq.size() != 0));
`endif
        if (out_valid === 1'b1) begin
            if (mq.size() == 0) begin
                chk("out_valid_unexpected", 16'(out_valid), 16'h0);
            end else begin
                chk("head_xyz", 16'({x_nib, y_nib, z_nib}), 16'(mq[0]));
            end
        end else begin
            chk("idle_xyz_zero", 16'({x_nib, y_nib, z_nib}), 16'h0);
        end
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (pop && mq.size() > 0) begin
            void'(mq.pop_front());
            npop++;
        end
        if (acc) begin
            mq.push_back(model(a_state));
            nacc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          sacc;
        int          spop;
        logic [39:0] p, q;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_state   = '0;

        // Hand-computed pins of the model.
        chk("model_zero", {4'h0, model(40'h0)}, 16'h0B38);
        chk("model_tap2_1", {4'h0, model(40'h1 << 24)}, 16'h0930);

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_occupancy", 16'(occupancy), 16'h0);
        chk("rst_xyz", 16'({x_nib, y_nib, z_nib}), 16'h0);

        // All-zero snapshot: sbox2(0)=3 sets x[1] and z[3].
        a_state  = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef CSA_SBOX_PIPE_EN
        tick();
`endif
        chk("zero_out_valid", 16'(out_valid), 16'h1);
        chk("zero_x", 16'(x_nib), 16'hB);
        chk("zero_y", 16'(y_nib), 16'h3);
        chk("zero_z", 16'(z_nib), 16'h8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Only tap [2][1] set: sbox2 input 5'h02 gives 0.
        a_state  = 40'h1 << 24;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef CSA_SBOX_PIPE_EN
        tick();
`endif
        chk("tap_out_valid", 16'(out_valid), 16'h1);
        chk("tap_x", 16'(x_nib), 16'h9);
        chk("tap_y", 16'(y_nib), 16'h3);
        chk("tap_z", 16'(z_nib), 16'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // Stalled consumer, three back-to-back offers: only two fit.
        sacc     = nacc;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_state = {8'($urandom), 32'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepts", 16'(nacc - sacc), 16'd2);
        chk("stall_occupancy", 16'(occupancy), 16'd2);
        chk("stall_in_ready", 16'(in_ready), 16'd0);
        out_ready = 1'b1;
        tick();
        chk("stall_ready_after_pop", 16'(in_ready), 16'd1);
        cyc = 0;
        while (mq.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("stall_drained", 16'(mq.size()), 16'd0);

        // 100 random snapshots streamed with the consumer always ready.
        sacc     = nacc;
        spop     = npop;
        cyc      = 0;
        in_valid = 1'b1;
        while ((nacc - sacc) < 100 && cyc < 1000) begin
            a_state = {8'($urandom), 32'($urandom)};
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", 16'(nacc - sacc), 16'd100);
`ifndef CSA_SBOX_PIPE_EN
        chk("stream_cycles", 16'(cyc), 16'd100);
`endif
        cyc = 0;
        while (mq.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("stream_pops", 16'(npop - spop), 16'd100);

        // Reset while full: queued results must never appear.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_state = {8'($urandom), 32'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        chk("prerst_occupancy", 16'(occupancy), 16'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 16'(out_valid), 16'd0);
        chk("midrst_occupancy", 16'(occupancy), 16'd0);
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        out_ready = 1'b0;

        // Push and pop together at occupancy 1.
        p        = {8'($urandom), 32'($urandom)};
        q        = {8'($urandom), 32'($urandom)};
        a_state  = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef CSA_SBOX_PIPE_EN
        tick();
`endif
        chk("pp_pre_occupancy", 16'(occupancy), 16'd1);
        chk("pp_pre_head", 16'({x_nib, y_nib, z_nib}), 16'(model(p)));
        a_state   = q;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_occupancy", 16'(occupancy), 16'd1);
`ifdef CSA_SBOX_PIPE_EN
        tick();
`endif
        chk("pp_new_head", 16'({x_nib, y_nib, z_nib}), 16'(model(q)));
        out_ready = 1'b1;
        tick();
        tick();
        chk("pp_final_empty", 16'(mq.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
